// File: rtl/sr_excitation_driver.sv
// Drives set/reset excitation pulses into an external SR flip-flop and verifies
// the result through its Q feedback, re-pulsing a bounded number of times before latching an error.
module sr_excitation_driver #(
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       S,
  output logic       R,
  input  logic       q_fb,
  input  logic       clr_err,
  output logic       busy,
  output logic       err,
  output logic [7:0] mismatch_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_CHECK,
    ST_ERROR
  } state_t;

  state_t     state_reg, state_next;
  logic       target_reg, target_next;
  logic       q_model_reg, q_model_next;
  logic [2:0] retry_reg, retry_next;
  logic [3:0] wait_reg, wait_next;
  logic [7:0] mcnt_reg, mcnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      target_reg  <= 1'b0;
      q_model_reg <= 1'b0;
      retry_reg   <= 3'd0;
      wait_reg    <= 4'd0;
      mcnt_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      q_model_reg <= q_model_next;
      retry_reg   <= retry_next;
      wait_reg    <= wait_next;
      mcnt_reg    <= mcnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    q_model_next = q_model_reg;
    retry_next   = retry_reg;
    wait_next    = wait_reg;
    mcnt_next    = mcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          target_next = in_bit;
          retry_next  = 3'd0;
          state_next  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        wait_next  = 4'(SETTLE - 1);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_reg == 4'd0) state_next = ST_CHECK;
        else                  wait_next  = wait_reg - 4'd1;
      end
      ST_CHECK: begin
        if (q_fb == target_reg) begin
          q_model_next = target_reg;
          state_next   = ST_IDLE;
        end else begin
          if (mcnt_reg != 8'hFF) mcnt_next = mcnt_reg + 8'd1;
          // Trust the observed Q so the next pulse actually corrects it.
          q_model_next = q_fb;
          if (retry_reg < 3'(MAX_RETRY)) begin
            retry_next = retry_reg + 3'd1;
            state_next = ST_PULSE;
          end else begin
            state_next = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (clr_err) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // S and R decode from registered state only, so they can never both be high.
  assign S            = (state_reg == ST_PULSE) &  target_reg & ~q_model_reg;
  assign R            = (state_reg == ST_PULSE) & ~target_reg &  q_model_reg;
  assign in_ready     = (state_reg == ST_IDLE);
  assign err          = (state_reg == ST_ERROR);
  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_ERROR);
  assign mismatch_cnt = mcnt_reg;

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Randomized and directed bench for sr_excitation_driver against a
// transaction-level model of pulses, retries, latency and error counting.
module tb_sr_excitation_driver;
  localparam int SETTLE    = 1;
  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic       S, R;
  logic       q_fb;
  logic       clr_err = 1'b0;
  logic       busy, err;
  logic [7:0] mismatch_cnt;

  // external flop and feedback distortion controls
  logic q_ext;
  logic stuck_en = 1'b0;
  logic stuck_val = 1'b0;
  logic fb_flip = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_qm = 1'b0;
  bit m_ext = 1'b0;
  int m_cnt = 0;

  sr_excitation_driver #(.SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .S(S), .R(R), .q_fb(q_fb), .clr_err(clr_err),
    .busy(busy), .err(err), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst)   q_ext <= 1'b0;
    else if (S) q_ext <= 1'b1;
    else if (R) q_ext <= 1'b0;
  end

  assign q_fb = (stuck_en ? stuck_val : q_ext) ^ fb_flip;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) chk("s_and_r_exclusive", 32'(S & R), 32'd0);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    clr_err = 1'b0;
    #1;
    chk("rst_s", 32'(S), 0);
    chk("rst_r", 32'(R), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(mismatch_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    m_qm = 1'b0;
    m_ext = 1'b0;
    m_cnt = 0;
  endtask

  // Offer one target, predict the whole transaction, then observe it.
  task automatic send(input bit b, input bit glitch, input bit noise, output bit e_err);
    int es, er, att, lat, s_seen, r_seen;
    bit qm, fb, ok, done;
    es = 0; er = 0; att = 0; ok = 1'b0; qm = m_qm;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      att++;
      if (b && !qm)      begin es++; m_ext = 1'b1; end
      else if (!b && qm) begin er++; m_ext = 1'b0; end
      fb = (stuck_en ? stuck_val : m_ext) ^ (glitch && a == 0);
      if (fb == b) begin
        qm = b; ok = 1'b1;
        break;
      end
      if (m_cnt < 255) m_cnt++;
      qm = fb;
    end
    m_qm = qm;
    e_err = !ok;

    chk("ready_before_send", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_bit = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s_seen = 0; r_seen = 0; lat = 0; done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      fb_flip = glitch && (lat == SETTLE + 2);
      s_seen += int'(S);
      r_seen += int'(R);
      if (in_ready || err) done = 1'b1;
      else if (noise) begin
        in_valid = 1'($urandom_range(1));
        in_bit   = 1'($urandom_range(1));
        clr_err  = 1'($urandom_range(1));
      end
    end
    in_valid = 1'b0;
    clr_err = 1'b0;
    fb_flip = 1'b0;
    chk("txn_done", 32'(done), 1);
    chk("s_pulses", 32'(s_seen), 32'(es));
    chk("r_pulses", 32'(r_seen), 32'(er));
    chk("latency", 32'(lat), 32'(att * (SETTLE + 2) + 1));
    chk("err", 32'(err), 32'(e_err));
    chk("in_ready_after", 32'(in_ready), 32'(!e_err));
    chk("busy_after", 32'(busy), 0);
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_cnt));
  endtask

  task automatic pulse_clr(input bit expect_err);
    @(negedge clk);
    chk("err_before_clr", 32'(err), 32'(expect_err));
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("clr_err_low", 32'(err), 0);
    chk("clr_ready", 32'(in_ready), 1);
    chk("clr_cnt_kept", 32'(mismatch_cnt), 32'(m_cnt));
  endtask

  initial begin
    bit e;
    do_reset();

    // ideal flop: S pulse, hold, R pulse
    send(1'b1, 1'b0, 1'b0, e);
    send(1'b1, 1'b0, 1'b0, e);
    send(1'b0, 1'b0, 1'b0, e);

    // stuck-at-0 feedback exhausts retries, then recovery after clr_err
    do_reset();
    stuck_en = 1'b1; stuck_val = 1'b0;
    send(1'b1, 1'b0, 1'b0, e);
    chk("stuck_err_flag", 32'(e), 1);
    chk("stuck_cnt3", 32'(mismatch_cnt), 3);
    pulse_clr(1'b1);
    send(1'b0, 1'b0, 1'b0, e);
    chk("recover_cnt3", 32'(mismatch_cnt), 3);
    stuck_en = 1'b0;

    // one-time feedback glitch on first check
    do_reset();
    send(1'b1, 1'b1, 1'b0, e);
    chk("glitch_cnt1", 32'(mismatch_cnt), 1);

    // reset asserted in the middle of an S pulse
    do_reset();
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pulse_s_high", 32'(S), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_s_drop", 32'(S), 0);
    chk("async_r_drop", 32'(R), 0);
    chk("async_ready", 32'(in_ready), 1);
    chk("async_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    m_qm = 1'b0; m_ext = 1'b0; m_cnt = 0;
    send(1'b1, 1'b0, 1'b0, e);

    // drive the mismatch counter into saturation
    stuck_en = 1'b1; stuck_val = 1'b0;
    for (int k = 0; k < 100 && m_cnt < 255; k++) begin
      send(1'b1, 1'b0, 1'b0, e);
      if (e) pulse_clr(1'b1);
    end
    send(1'b1, 1'b0, 1'b0, e);
    if (e) pulse_clr(1'b1);
    chk("cnt_saturated", 32'(mismatch_cnt), 255);
    stuck_en = 1'b0;

    // random run with noisy inputs while busy
    for (int i = 0; i < 10000; i++) begin
      int r;
      bit g;
      r = int'($urandom_range(9));
      stuck_en = (r == 0);
      stuck_val = 1'($urandom_range(1));
      g = (r == 1);
      if (r == 2) begin
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("idle_clr_ready", 32'(in_ready), 1);
        chk("idle_clr_err", 32'(err), 0);
      end
      send(1'($urandom_range(1)), g, 1'b1, e);
      if (e) pulse_clr(1'b1);
    end
    stuck_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_excitation_driver.md
SR_EXCITATION_DRIVER -- requirements
Module: sr_excitation_driver

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of wait cycles after an excitation pulse before q_fb is sampled (legal range 1-15).
REQ-002 The block SHALL have parameter MAX_RETRY, default 2, meaning the number of re-pulses allowed after a failed check before entering ERROR (legal range 0-7).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 in_valid  input  1  a target bit is offered.
REQ-007 in_bit  input  1  target value for the external SR flip-flop Q.
REQ-008 in_ready  output  1  block can accept a target bit this cycle.
REQ-009 S  output  1  set excitation to the external SR flip-flop.
REQ-010 R  output  1  reset excitation to the external SR flip-flop.
REQ-011 q_fb  input  1  Q fed back from the external SR flip-flop.
REQ-012 clr_err  input  1  clears ERROR state; single-cycle pulse.
REQ-013 busy  output  1  a target bit is in flight (state not IDLE or ERROR).
REQ-014 err  output  1  sticky error flag; high exactly while in ERROR.
REQ-015 mismatch_cnt  output  8  saturating count of failed feedback checks.

Function
REQ-016 The block SHALL implement the states IDLE, PULSE, WAIT, CHECK and ERROR; in_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur when in_valid=1 and in_ready=1; the block SHALL latch in_bit as the target and move to PULSE.
REQ-018 In PULSE, lasting exactly one cycle, the block SHALL drive S=1,R=0 if target=1 and q_model=0; S=0,R=1 if target=0 and q_model=1; and S=0,R=0 (hold) if target=q_model.
REQ-019 Outside PULSE, S and R SHALL both be 0; S=1 with R=1 SHALL never be driven in any state, including reset.
REQ-020 After PULSE, the block SHALL spend exactly SETTLE cycles in WAIT, then one cycle in CHECK, where q_fb is sampled.
REQ-021 A first-attempt accept-to-IDLE latency SHALL be SETTLE+3 cycles (accept edge, PULSE, WAIT x SETTLE, CHECK).
REQ-022 In CHECK, if q_fb equals target, the block SHALL set q_model=target and return to IDLE.
REQ-023 In CHECK, if q_fb differs, the block SHALL increment mismatch_cnt and saturate it at 255.
REQ-024 On a mismatch with retry count < MAX_RETRY, the block SHALL increment the retry count and return to PULSE, recomputing S/R from q_model=q_fb so that a correcting pulse is issued.
REQ-025 On a mismatch with retry count = MAX_RETRY, the block SHALL enter ERROR, set q_model=q_fb and hold err=1.
REQ-026 The retry count SHALL be cleared on every accepted transfer.
REQ-027 In ERROR, in_ready SHALL be 0 and S=R=0; clr_err=1 SHALL return the block to IDLE on the next edge.
REQ-028 mismatch_cnt SHALL be kept through clr_err.
REQ-029 clr_err asserted outside ERROR SHALL have no effect.
REQ-030 in_valid and in_bit SHALL be ignored whenever in_ready=0.
REQ-031 A transfer SHALL be accepted on the same edge the block returns to IDLE only if in_ready was 1 on that edge; there is no back-to-back bypass, so the minimum accept spacing is SETTLE+3 cycles.

Reset
REQ-032 While rst=0, the block SHALL immediately force state=IDLE, S=0, R=0, err=0, busy=0, in_ready=1, q_model=0, retry count=0 and mismatch_cnt=0, independent of clk.
REQ-033 Reset asserted mid-operation, including during PULSE, SHALL drop S and R to 0 asynchronously and abandon the in-flight target.
REQ-034 After rst deasserts, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-035 Bench SHALL cover: SETTLE=1 with an ideal flop model; send 1,1,0 -> S pulse, hold (S=R=0), R pulse; each returns to IDLE after 4 cycles; mismatch_cnt=0.
REQ-036 Bench SHALL cover: q_fb stuck at 0, MAX_RETRY=2, send 1 -> three S pulses, mismatch_cnt=3, err=1, in_ready=0.
REQ-037 Bench SHALL cover: from REQ-036's end, pulse clr_err, then send 0 with q_fb=0 -> hold pulse, success, err=0, mismatch_cnt stays 3.
REQ-038 Bench SHALL cover: one-time q_fb glitch on the first CHECK of target 1 -> exactly one retry S pulse, success, mismatch_cnt=1, err=0.
REQ-039 Bench SHALL cover: rst low during PULSE with S=1 -> S=0 within the same cycle; after release, in_ready=1 and q_model=0, so sending 1 yields an S pulse.
REQ-040 Bench SHALL cover: a random run of 10k targets with an assertion S&R==0 every cycle, and mismatch_cnt saturating at 255 under a stuck q_fb.
